// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and sizing for the hazard/scoreboard controller.
package hazard_scoreboard_ctrl_pkg;

   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);
   localparam int CNT_W  = 32;
   localparam int INF_W  = 4;

   // custom-0 major opcode used by the multi-cycle DSP instructions
   localparam logic [6:0] OPC_DSP = 7'b0001011;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [2:0] {
      HZ_NONE     = 3'd0,
      HZ_LOAD_USE = 3'd1,
      HZ_DSP_RAW  = 3'd2,
      HZ_DSP_WAW  = 3'd3,
      HZ_DSP_FULL = 3'd4
   } hazard_e;

   // Operand bypass select: MEM is younger than WB so it wins; x0 never bypasses.
   function automatic fwd_sel_e fwd_select(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] mem_rd,
      input logic              mem_we,
      input logic [REG_AW-1:0] wb_rd,
      input logic              wb_we
   );
      fwd_sel_e sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (mem_we && (mem_rd == rs))
            sel = FWD_MEM;
         else if (wb_we && (wb_rd == rs))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller: stage info in, control out.
interface hazard_scoreboard_ctrl_if;
   import hazard_scoreboard_ctrl_pkg::*;

   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_is_dsp;
   logic              ex_valid;
   logic [REG_AW-1:0] ex_rs1;
   logic [REG_AW-1:0] ex_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_mem_read;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_reg_write;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write;
   logic              dsp_wb_valid;
   logic [REG_AW-1:0] dsp_wb_rd;
   logic              redirect;

   logic              pc_stall;
   logic              if_stall;
   logic              id_stall;
   logic              ex_bubble;
   logic              if_flush;
   logic              id_flush;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [2:0]        hazard_type;
   logic [INF_W-1:0]  dsp_inflight;
   logic              stall_timeout;
   logic [CNT_W-1:0]  perf_stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_dsp,
      output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
      output mem_rd, mem_reg_write, wb_rd, wb_reg_write, dsp_wb_valid, dsp_wb_rd, redirect,
      input  pc_stall, if_stall, id_stall, ex_bubble, if_flush, id_flush,
      input  fwd_a, fwd_b, hazard_type, dsp_inflight, stall_timeout, perf_stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_dsp,
      input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
      input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, dsp_wb_valid, dsp_wb_rd, redirect,
      output pc_stall, if_stall, id_stall, ex_bubble, if_flush, id_flush,
      output fwd_a, fwd_b, hazard_type, dsp_inflight, stall_timeout, perf_stall_cnt
   );

endinterface

// File: rtl/hazard_scoreboard_ctrl_dsp_scoreboard.sv
// Busy-register scoreboard and in-flight counter for multi-cycle DSP ops.
module hazard_scoreboard_ctrl_dsp_scoreboard
   import hazard_scoreboard_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_i,
   input  logic              issue_we_i,
   input  logic [REG_AW-1:0] issue_rd_i,
   input  logic              retire_i,
   input  logic [REG_AW-1:0] retire_rd_i,
   output logic [NREGS-1:0]  busy_o,
   output logic [INF_W-1:0]  inflight_o
);

   logic [INF_W-1:0] inflight_q;
   logic [INF_W-1:0] inflight_d;
   logic             retire_ok;

   // A retirement with nothing outstanding is stale (e.g. from before a reset) and is dropped.
   assign retire_ok = retire_i && (inflight_q != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_busy
         if (gi == 0) begin : g_x0
            assign busy_o[gi] = 1'b0;
         end else begin : g_reg
            logic bit_q;
            logic set_w;
            logic clr_w;
            assign set_w = issue_i && issue_we_i && (issue_rd_i == REG_AW'(gi));
            assign clr_w = retire_ok && (retire_rd_i == REG_AW'(gi));
            // Busy bit: a new issue to the register outranks a same-cycle retirement.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)     bit_q <= 1'b0;
               else if (set_w) bit_q <= 1'b1;
               else if (clr_w) bit_q <= 1'b0;
            end
            assign busy_o[gi] = bit_q;
         end
      end
   endgenerate

   // In-flight count: issue and retire together cancel out.
   always_comb begin
      inflight_d = inflight_q;
      if (issue_i && !retire_ok)
         inflight_d = inflight_q + 1'b1;
      else if (!issue_i && retire_ok)
         inflight_d = inflight_q - 1'b1;
   end

   // In-flight counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= '0;
      else        inflight_q <= inflight_d;
   end

   assign inflight_o = inflight_q;

   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      retire_i |-> (inflight_q != '0));

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage hazard detection, EX operand forwarding and stall statistics.
module hazard_scoreboard_ctrl
   import hazard_scoreboard_ctrl_pkg::*;
#(
   parameter int MAX_DSP_INF = 4,
   parameter int STALL_TMO   = 64
) (
   input logic                    clk,
   input logic                    rst_n,
   hazard_scoreboard_ctrl_if.slave hz
);

   localparam int RUN_W = $clog2(STALL_TMO + 1);

   logic [NREGS-1:0] busy;
   logic [INF_W-1:0] inflight;
   logic             lu_hit, raw_hit, waw_hit, full_hit, hazard_any;
   logic             stall_w, flush_w, issue_w;
   hazard_e          htype_w;

   logic [RUN_W-1:0] run_q, run_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] perf_q, perf_d;

   // Hazard classification for the ID instruction, highest priority first.
   always_comb begin
      lu_hit   = hz.id_valid && hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != '0) &&
                 ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                  (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
      raw_hit  = hz.id_valid && ((hz.id_use_rs1 && busy[hz.id_rs1]) ||
                                 (hz.id_use_rs2 && busy[hz.id_rs2]));
      waw_hit  = hz.id_valid && hz.id_reg_write && busy[hz.id_rd];
      full_hit = hz.id_valid && hz.id_is_dsp && (inflight == INF_W'(MAX_DSP_INF));
      htype_w  = HZ_NONE;
      if (lu_hit)        htype_w = HZ_LOAD_USE;
      else if (raw_hit)  htype_w = HZ_DSP_RAW;
      else if (waw_hit)  htype_w = HZ_DSP_WAW;
      else if (full_hit) htype_w = HZ_DSP_FULL;
      hazard_any = lu_hit || raw_hit || waw_hit || full_hit;
   end

   // A taken redirect squashes the ID instruction, so it overrides any stall.
   assign stall_w = rst_n && hazard_any && !hz.redirect;
   assign flush_w = rst_n && hz.redirect;
   assign issue_w = hz.id_valid && hz.id_is_dsp && !hazard_any && !hz.redirect;

   assign hz.pc_stall    = stall_w;
   assign hz.if_stall    = stall_w;
   assign hz.id_stall    = stall_w;
   assign hz.ex_bubble   = stall_w || flush_w;
   assign hz.if_flush    = flush_w;
   assign hz.id_flush    = flush_w;
   assign hz.hazard_type = (rst_n && !hz.redirect) ? htype_w : HZ_NONE;
   assign hz.fwd_a = rst_n ? fwd_select(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write) : FWD_RF;
   assign hz.fwd_b = rst_n ? fwd_select(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write) : FWD_RF;

   hazard_scoreboard_ctrl_dsp_scoreboard u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_i     (issue_w),
      .issue_we_i  (hz.id_reg_write),
      .issue_rd_i  (hz.id_rd),
      .retire_i    (hz.dsp_wb_valid),
      .retire_rd_i (hz.dsp_wb_rd),
      .busy_o      (busy),
      .inflight_o  (inflight)
   );

   assign hz.dsp_inflight   = inflight;
   assign hz.stall_timeout  = timeout_q;
   assign hz.perf_stall_cnt = perf_q;

   // Stall run length (saturates at the timeout), sticky watchdog, saturating total.
   always_comb begin
      run_d = '0;
      if (stall_w)
         run_d = (run_q == RUN_W'(STALL_TMO)) ? run_q : run_q + 1'b1;
      timeout_d = timeout_q || (run_d == RUN_W'(STALL_TMO));
      perf_d    = (stall_w && !(&perf_q)) ? perf_q + 1'b1 : perf_q;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= '0;
         timeout_q <= 1'b0;
         perf_q    <= '0;
      end else begin
         run_q     <= run_d;
         timeout_q <= timeout_d;
         perf_q    <= perf_d;
      end
   end

endmodule
